red_mod_p_seq: RTL and testbench

Sequential reducer that maps an (8+d)-bit redundant RAMBAM word back to its 8-bit field value by polynomial division modulo P over GF(2). It is the decode-side counterpart of the P-multiple masking logic. It sits at the output boundary of the masked datapath, where redundant words are unmasked. Processing is bit-serial, MSB first, one coefficient per cycle, with valid/ready handshakes on both sides.

---
 rtl/red_mod_p_seq_if.sv | 22 ++
 rtl/red_mod_p_seq.sv | 76 +++++++
 tb/tb_red_mod_p_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/red_mod_p_seq_if.sv
// Handshake bundle for the redundant-word reducer: input word channel and remainder result channel.
interface red_mod_p_seq_if #(
    parameter int D = 4
);
    logic [0:7+D] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [0:7]   out_data;
    logic         out_zero;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_zero, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_zero, out_valid
    );
endinterface

// File: rtl/red_mod_p_seq.sv
// Bit-serial GF(2) reducer: folds an (8+D)-bit redundant word back to its 8-bit value mod P, MSB first.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SHIFT | consuming one coefficient per cycle into the remainder
// DONE  | remainder presented, held until out_ready
module red_mod_p_seq #(
    parameter int         D = 4,
    parameter logic [0:8] P = 9'b1_0001_1011
) (
    input  logic           clk,
    input  logic           rst_n,
    red_mod_p_seq_if.slave bus
);
    localparam int W  = 8 + D;
    localparam int CW = $clog2(9 + D);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [0:W-1]    sreg;
    logic [0:7]      rem;
    logic [CW-1:0]   cnt;
    logic            in_ready_r;
    logic            out_valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sreg        <= '0;
            rem         <= '0;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg       <= bus.in_data;
                        rem        <= '0;
                        cnt        <= CW'(W);
                        in_ready_r <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Shift the next coefficient in; a set x^8 term is cancelled by subtracting P.
                    sreg <= {sreg[1:W-1], 1'b0};
                    rem  <= {rem[1:7], sreg[0]} ^ (rem[0] ? P[1:8] : 8'h00);
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = rem;
    assign bus.out_zero  = (rem == 8'h00);
endmodule

// File: tb/tb_red_mod_p_seq.sv
// Directed bench for red_mod_p_seq (D=4, P=0x11B) with a polynomial-division reference model.
module tb_red_mod_p_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;

    logic [7:0] exp_q[$];
    int         acc_t[$];

    red_mod_p_seq_if #(.D(4)) bus ();

    red_mod_p_seq #(.D(4), .P(9'b1_0001_1011)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mod(input logic [11:0] x);
        logic [11:0] t;
        t = x;
        for (int i = 11; i >= 8; i--)
            if (t[i]) t = t ^ (12'h11B << (i - 8));
        return t[7:0];
    endfunction

    function automatic logic [11:0] gf_mul_p(input logic [3:0] r);
        logic [11:0] t;
        t = '0;
        for (int i = 0; i < 4; i++)
            if (r[i]) t = t ^ (12'h11B << i);
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model side: record every accepted word's expected remainder, retire it when consumed.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(gf_mod(bus.in_data));
                acc_t.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_out_valid: got out_data 0x%0h with no word pending", bus.out_data);
            end else begin
                check("model_out_data", 32'(bus.out_data), 32'(exp_q[0]));
                check("model_out_zero", 32'(bus.out_zero), 32'(exp_q[0] == 8'h00));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_timeout", 32'(n < 40), 32'd1);
    endtask

    task automatic run_word(input logic [11:0] w, input logic [7:0] lit, input bit use_lit, input string name);
        int n, acc;
        wait_ready();
        @(negedge clk);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 40);
        check({name, "_valid_timeout"}, 32'(bus.out_valid), 32'd1);
        check({name, "_latency"}, 32'(cyc - acc), 32'd12);
        if (use_lit) begin
            check({name, "_data"}, 32'(bus.out_data), 32'(lit));
            check({name, "_zero"}, 32'(bus.out_zero), 32'(lit == 8'h00));
        end
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
            check({name, "_consumed_valid"}, 32'(bus.out_valid), 32'd0);
            check({name, "_consumed_ready"}, 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, nv;
        logic [11:0] bb_words[4];
        logic [7:0]  v;
        logic [3:0]  r;

        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'h00);
        check("rst_out_zero", 32'(bus.out_zero), 32'd1);
        rst_n = 1'b1;

        run_word(12'h100, 8'h1B, 1'b1, "x8");
        run_word(12'h800, 8'hD8, 1'b1, "x11");
        run_word(12'h0AB, 8'hAB, 1'b1, "low_deg");
        run_word(12'hFFF, 8'h00, 1'b0, "all_ones");
        run_word(12'h8D8, 8'h00, 1'b1, "p_x3");
        run_word(12'h11B, 8'h00, 1'b1, "p");
        for (int i = 0; i < 16; i++) run_word(gf_mul_p(4'(i)), 8'h00, 1'b1, "p_mult");

        // Backpressure in DONE.
        bus.out_ready = 1'b0;
        run_word(12'h0C5, 8'hC5, 1'b1, "bp");
        repeat (20) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_data", 32'(bus.out_data), 32'hC5);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);

        // in_valid toggling with junk while the word is busy must not be sampled.
        wait_ready();
        nv = acc_t.size();
        @(negedge clk);
        bus.in_data  = 12'h5A3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.in_data  = 12'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_ready();
        check("toggle_accepts", 32'(acc_t.size() - nv), 32'd1);

        // Reset mid-SHIFT abandons the word.
        wait_ready();
        @(negedge clk);
        bus.in_data  = 12'h100;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_zero", 32'(bus.out_zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        check("midrst_no_valid", 32'(n), 32'd0);
        run_word(12'h0AB, 8'hAB, 1'b1, "after_rst");

        // Back-to-back words with in_valid held high.
        bb_words[0] = 12'h100;
        bb_words[1] = 12'h800;
        bb_words[2] = 12'h3C7;
        bb_words[3] = 12'h0AB;
        wait_ready();
        nv = acc_t.size();
        @(negedge clk);
        bus.in_data  = bb_words[0];
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n = 0;
            while (acc_t.size() < nv + i && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("bb_accept_timeout", 32'(n < 40), 32'd1);
            if (i < 4) bus.in_data = bb_words[i];
        end
        bus.in_valid = 1'b0;
        if (acc_t.size() >= nv + 4)
            for (int i = 1; i < 4; i++)
                check("bb_spacing", 32'(acc_t[nv + i] - acc_t[nv + i - 1]), 32'd14);
        wait_ready();

        // Masked round trip: (P*r) ^ v reduces to v.
        for (int it = 0; it < 1000; it++) begin
            v = 8'($urandom_range(0, 255));
            r = 4'($urandom_range(0, 15));
            k = it;
            run_word(gf_mul_p(r) ^ {4'h0, v}, v, 1'b1, "roundtrip");
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
